// File: rtl/dpb_master_rd_if.sv
// Ready/valid beat stream from the DPB read stage to the DDR3 write master.
interface dpb_master_rd_if;
  logic         valid;
  logic         ready;
  logic [127:0] data;
  logic         sop;
  logic         eop;
  logic [7:0]   udp_rank;
  logic [4:0]   last_bytes;
  logic         frame_end;

  modport master (output valid, data, sop, eop, udp_rank, last_bytes, frame_end, input ready);
  modport slave  (input valid, data, sop, eop, udp_rank, last_bytes, frame_end, output ready);
endinterface

// File: rtl/dpb_master_rd.sv
// DPB port-B read stage: queues packet descriptors from the writer, reads each
// packet's words back and streams them with sop/eop/frame framing to DDR3.
module dpb_master_rd #(
  parameter int RD_LATENCY = 2,
  parameter int DESC_DEPTH = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic           i_pclk,
  input  logic           i_rst_n,
  input  logic           i_wr_req,
  input  logic           i_wr_frame_down,
  input  logic [7:0]     i_wr_udp_rank,
  input  logic [3:0]     i_wr_buf_rank,
  input  logic [6:0]     i_wr_buf_128cnt,
  input  logic [5:0]     i_wr_buf_Bytecnt,
  output logic           o_wr_down,
  output logic           o_dpb_rd_b_clk,
  output logic           o_dpb_rd_b_cea,
  output logic           o_dpb_rd_b_ocea,
  output logic           o_dpb_rd_b_rst_n,
  output logic           o_dpb_rd_b_wr_en,
  output logic [127:0]   o_dpb_rd_b_wr_data,
  output logic [10:0]    o_dpb_rd_b_addr,
  input  logic [127:0]   i_dpb_rd_b_rd_data,
  dpb_master_rd_if.master ddr3,
  output logic           o_error
);
  typedef struct packed {
    logic [7:0] udp_rank;
    logic [3:0] buf_rank;
    logic [6:0] cnt;
    logic [5:0] bytecnt;
    logic       frame_end;
  } desc_t;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
  } beat_t;

  localparam int QAW = $clog2(DESC_DEPTH);
  localparam int FAW = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(OUT_DEPTH + RD_LATENCY + 1);
  localparam logic [QAW:0]  Q_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  assign o_dpb_rd_b_clk     = i_pclk;
  assign o_dpb_rd_b_cea     = 1'b1;
  assign o_dpb_rd_b_ocea    = 1'b1;
  assign o_dpb_rd_b_rst_n   = 1'b0;
  assign o_dpb_rd_b_wr_en   = 1'b0;
  assign o_dpb_rd_b_wr_data = '0;

  // ---------------- descriptor queue ----------------
  logic         fd_q, fd_rise, push, q_pop, q_empty, q_full;
  logic [QAW:0] q_wp, q_rp;
  desc_t        q_mem [DESC_DEPTH];
  desc_t        q_in;
  logic [1:0]   state;

  assign fd_rise = i_wr_frame_down & ~fd_q;
  assign push    = i_wr_req | fd_rise;
  assign q_in    = {i_wr_udp_rank, i_wr_buf_rank, i_wr_buf_128cnt, i_wr_buf_Bytecnt, fd_rise};
  assign q_empty = (q_wp == q_rp);
  assign q_full  = (q_wp[QAW] != q_rp[QAW]) && (q_wp[QAW-1:0] == q_rp[QAW-1:0]);
  assign q_pop   = (state == S_IDLE) && !q_empty;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fd_q    <= 1'b0;
      q_wp    <= '0;
      q_rp    <= '0;
      o_error <= 1'b0;
    end else begin
      fd_q <= i_wr_frame_down;
      if (push && !q_full) q_wp <= q_wp + Q_ONE;
      if (push && q_full)  o_error <= 1'b1;
      if (q_pop)           q_rp <= q_rp + Q_ONE;
    end
  end

  always_ff @(posedge i_pclk)
    if (push && !q_full) q_mem[q_wp[QAW-1:0]] <= q_in;

  // ---------------- read issue and tag pipeline ----------------
  desc_t                cur;
  logic [6:0]           issued;
  logic [10:0]          addr;
  logic [RD_LATENCY:1]  vld_pipe;
  logic [6:0]           tag_pipe [RD_LATENCY:1];
  logic [CW-1:0]        fifo_cnt, inflight;
  logic                 rd_issue, f_push, f_pop;
  logic [FAW-1:0]       f_wp, f_rp;
  beat_t                fifo_mem [OUT_DEPTH];
  beat_t                head, f_in;

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= RD_LATENCY; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  // Credit check: every read in flight already owns a FIFO slot.
  assign rd_issue = (state == S_READ) && (issued != cur.cnt) &&
                    ((fifo_cnt + inflight) < CW'(OUT_DEPTH));

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd_issue;
      for (int k = 2; k <= RD_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_ff @(posedge i_pclk) begin
    tag_pipe[1] <= issued;
    for (int k = 2; k <= RD_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
  end

  // ---------------- output FIFO ----------------
  function automatic logic [FAW-1:0] f_nxt(input logic [FAW-1:0] p);
    return (p == FAW'(OUT_DEPTH - 1)) ? '0 : p + FAW'(1);
  endfunction

  assign f_push = vld_pipe[RD_LATENCY];
  assign f_in   = {i_dpb_rd_b_rd_data, tag_pipe[RD_LATENCY] == 7'd0,
                   tag_pipe[RD_LATENCY] == cur.cnt - 7'd1};
  assign head   = fifo_mem[f_rp];
  assign f_pop  = ddr3.valid & ddr3.ready;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_wp     <= '0;
      f_rp     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (f_push) f_wp <= f_nxt(f_wp);
      if (f_pop)  f_rp <= f_nxt(f_rp);
      case ({f_push, f_pop})
        2'b10:   fifo_cnt <= fifo_cnt + C_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - C_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_pclk)
    if (f_push) fifo_mem[f_wp] <= f_in;

  // Per-packet fields come from the working descriptor; it is held until eop retires.
  assign ddr3.valid      = (fifo_cnt != '0);
  assign ddr3.data       = ddr3.valid ? head.data : '0;
  assign ddr3.sop        = ddr3.valid & head.sop;
  assign ddr3.eop        = ddr3.valid & head.eop;
  assign ddr3.udp_rank   = ddr3.valid ? cur.udp_rank : '0;
  assign ddr3.last_bytes = !ddr3.valid ? 5'd0 :
                           (cur.bytecnt == 6'd0) ? 5'd16 : cur.bytecnt[4:0];
  assign ddr3.frame_end  = ddr3.valid & head.eop & cur.frame_end;
  assign o_dpb_rd_b_addr = addr;

  // ---------------- control FSM ----------------
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      issued    <= '0;
      addr      <= '0;
      o_wr_down <= 1'b0;
    end else begin
      o_wr_down <= 1'b0;
      case (state)
        S_IDLE: if (!q_empty) begin
          cur   <= q_mem[q_rp[QAW-1:0]];
          state <= S_LOAD;
        end
        S_LOAD: begin
          addr   <= {cur.buf_rank, 7'd1};
          issued <= '0;
          if (cur.cnt == 7'd0) begin
            state     <= S_IDLE;
            o_wr_down <= 1'b1;
          end else state <= S_READ;
        end
        S_READ: if (rd_issue) begin
          addr[6:0] <= addr[6:0] + 7'd1;
          issued    <= issued + 7'd1;
          if (issued == cur.cnt - 7'd1) state <= S_DRAIN;
        end
        S_DRAIN: if (f_pop && head.eop) begin
          state     <= S_IDLE;
          o_wr_down <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
